// File: rtl/ahb_to_apb_bridge_nslv.sv
// AHB-Lite slave to APB4 master bridge with P_NUM equal-size peripheral slots.
// One APB transfer per AHB transfer; PSLVERR, unmapped hits and PREADY timeout
// all produce a two-cycle AHB ERROR response.
module ahb_to_apb_bridge_nslv #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned P_NUM      = 4,
  parameter logic [15:0] P_BASE     = 16'hC000,
  parameter logic [15:0] P_STRIDE   = 16'h0010,
  parameter int unsigned P_TIMEOUT  = 256
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic                        HSEL,
  input  logic [ADDR_WIDTH-1:0]       HADDR,
  input  logic [1:0]                  HTRANS,
  input  logic                        HWRITE,
  input  logic [2:0]                  HSIZE,
  input  logic [3:0]                  HPROT,
  input  logic [DATA_WIDTH-1:0]       HWDATA,
  input  logic                        HREADYIN,
  output logic                        HREADYOUT,
  output logic                        HRESP,
  output logic [DATA_WIDTH-1:0]       HRDATA,
  output logic [P_NUM-1:0]            PSEL,
  output logic                        PENABLE,
  output logic [ADDR_WIDTH-1:0]       PADDR,
  output logic                        PWRITE,
  output logic [DATA_WIDTH-1:0]       PWDATA,
  output logic [3:0]                  PSTRB,
  output logic [2:0]                  PPROT,
  input  logic [P_NUM*DATA_WIDTH-1:0] PRDATA,
  input  logic [P_NUM-1:0]            PREADY,
  input  logic [P_NUM-1:0]            PSLVERR
);

  localparam int unsigned SlotW    = (P_NUM > 1) ? $clog2(P_NUM) : 1;
  localparam int unsigned StrideSh = $clog2(P_STRIDE);
  localparam int unsigned CntW     = (P_TIMEOUT > 0) ? $clog2(P_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {StIdle, StLatch, StSetup, StAccess, StErr1, StErr2} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [2:0]              size_q;
  logic [1:0]              prot_q;
  logic [SlotW-1:0]        slot_q;
  logic [CntW-1:0]         cnt_q;

  logic                    valid, accept, hit;
  logic [15:0]             region, off;
  logic [SlotW-1:0]        slot_dec;
  logic [P_NUM-1:0]        sel_1h;
  logic                    pready_sel, pslverr_sel, timeout_hit;
  logic [DATA_WIDTH-1:0]   prdata_sel;
  logic [3:0]              strb;
  logic                    unused_ok;

  assign unused_ok = ^{HTRANS[0], HPROT[3:2]};

  // Address decode: region offset from slot 0, slot index by shift.
  assign valid    = HSEL & HTRANS[1] & HREADYIN;
  assign accept   = valid & ((state_q == StIdle) | (state_q == StErr2));
  assign region   = 16'(HADDR >> 16);
  assign off      = region - P_BASE;
  assign hit      = (region >= P_BASE) && (32'(off) < P_NUM * 32'(P_STRIDE));
  assign slot_dec = SlotW'(off >> StrideSh);

  // Selected-slot views of the APB return signals.
  assign sel_1h      = P_NUM'(1) << slot_q;
  assign pready_sel  = |(PREADY & sel_1h);
  assign pslverr_sel = |(PSLVERR & sel_1h);
  assign prdata_sel  = DATA_WIDTH'(PRDATA >> (DATA_WIDTH * 32'(slot_q)));
  // Fires on the ACCESS cycle that would bring the wait count up to P_TIMEOUT.
  assign timeout_hit = (P_TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) >= P_TIMEOUT);

  // Byte strobes for the latched transfer; reads never strobe.
  always_comb begin
    strb = 4'b0000;
    if (write_q) begin
      case (size_q)
        3'd0:    strb = 4'b0001 << addr_q[1:0];
        3'd1:    strb = addr_q[1] ? 4'b1100 : 4'b0011;
        default: strb = 4'b1111;
      endcase
    end
  end

  // State register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StErr2: begin
        if (valid) state_d = hit ? StLatch : StErr1;
        else       state_d = StIdle;
      end
      StLatch:  state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: begin
        if (pready_sel)       state_d = pslverr_sel ? StErr1 : StIdle;
        else if (timeout_hit) state_d = StErr1;
      end
      StErr1:   state_d = StErr2;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    HREADYOUT = (state_q == StIdle) || (state_q == StErr2);
    HRESP     = (state_q == StErr1) || (state_q == StErr2);
    PENABLE   = (state_q == StAccess);
    PSEL      = ((state_q == StSetup) || (state_q == StAccess)) ? sel_1h : '0;
  end

  // Address-phase capture of the accepted AHB transfer.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
      prot_q  <= 2'd0;
      slot_q  <= '0;
    end else if (accept) begin
      addr_q  <= HADDR;
      write_q <= HWRITE;
      size_q  <= HSIZE;
      prot_q  <= HPROT[1:0];
      slot_q  <= slot_dec;
    end
  end

  // APB request registers, loaded on entry to SETUP and held until the next transfer.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
      PSTRB  <= 4'b0000;
      PPROT  <= 3'b000;
    end else if (state_q == StLatch) begin
      PADDR  <= addr_q;
      PWRITE <= write_q;
      PSTRB  <= strb;
      PPROT  <= {~prot_q[0], 1'b0, prot_q[1]};
      if (write_q) PWDATA <= HWDATA;
    end
  end

  // PREADY wait counter, cleared at SETUP.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q <= '0;
    end else if (state_q == StSetup) begin
      cnt_q <= '0;
    end else if ((state_q == StAccess) && !pready_sel && (P_TIMEOUT != 0)) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Read data capture; an errored read still loads PRDATA.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HRDATA <= '0;
    end else if ((state_q == StAccess) && pready_sel && !write_q) begin
      HRDATA <= prdata_sel;
    end
  end

endmodule

// File: tb/tb_ahb_to_apb_bridge_nslv.sv
// Self-checking bench for ahb_to_apb_bridge_nslv (P_NUM=4, P_TIMEOUT=8).
module tb_ahb_to_apb_bridge_nslv;

  localparam int unsigned PN = 4;
  localparam int unsigned TO = 8;

  logic              HCLK = 1'b0;
  logic              HRESETn;
  logic              HSEL;
  logic [31:0]       HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [3:0]        HPROT;
  logic [31:0]       HWDATA;
  logic              HREADYIN;
  logic              HREADYOUT;
  logic              HRESP;
  logic [31:0]       HRDATA;
  logic [PN-1:0]     PSEL;
  logic              PENABLE;
  logic [31:0]       PADDR;
  logic              PWRITE;
  logic [31:0]       PWDATA;
  logic [3:0]        PSTRB;
  logic [2:0]        PPROT;
  logic [PN*32-1:0]  PRDATA;
  logic [PN-1:0]     PREADY;
  logic [PN-1:0]     PSLVERR;

  always #5 HCLK = ~HCLK;

  ahb_to_apb_bridge_nslv #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .P_NUM     (PN),
    .P_BASE    (16'hC000),
    .P_STRIDE  (16'h0010),
    .P_TIMEOUT (TO)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .HSEL     (HSEL),
    .HADDR    (HADDR),
    .HTRANS   (HTRANS),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HPROT    (HPROT),
    .HWDATA   (HWDATA),
    .HREADYIN (HREADYIN),
    .HREADYOUT(HREADYOUT),
    .HRESP    (HRESP),
    .HRDATA   (HRDATA),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PSTRB    (PSTRB),
    .PPROT    (PPROT),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: what the bridge should be holding.
  logic [31:0] m_hrdata, m_pwdata;

  // Next transaction (t_*) and the one currently in its data phase (c_*).
  logic [31:0] t_addr, t_wdata, c_addr, c_wdata;
  bit          t_write, c_write, t_err, c_err;
  logic [2:0]  t_size, c_size;
  logic [3:0]  t_prot, c_prot;
  int unsigned t_wait, c_wait;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hit(input logic [31:0] a);
    int unsigned hi = a >> 16;
    return (hi >= 32'hC000) && ((hi - 32'hC000) < PN * 16);
  endfunction

  function automatic int unsigned m_slot(input logic [31:0] a);
    int unsigned hi = a >> 16;
    return (hi - 32'hC000) / 16;
  endfunction

  // Strobe covers the naturally aligned container of the access size.
  function automatic logic [3:0] m_strb(input bit w, input int unsigned sz, input logic [31:0] a);
    int unsigned nb, st;
    if (!w) return 4'b0000;
    nb = (sz >= 2) ? 4 : (1 << sz);
    st = ((a % 4) / nb) * nb;
    return 4'(((1 << nb) - 1) << st);
  endfunction

  function automatic logic [2:0] m_pprot(input logic [3:0] p);
    logic [2:0] r;
    r[0] = p[1];       // privileged
    r[1] = 1'b0;       // always secure
    r[2] = !p[0];      // instruction when not data
    return r;
  endfunction

  task automatic set_t(input logic [31:0] a, input bit w, input logic [2:0] sz,
                       input logic [3:0] p, input logic [31:0] d, input int unsigned wt,
                       input bit e);
    t_addr = a; t_write = w; t_size = sz; t_prot = p; t_wdata = d; t_wait = wt; t_err = e;
  endtask

  task automatic rand_t();
    int unsigned r, hi;
    int unsigned waits [8] = '{0, 0, 1, 2, 3, 7, 8, 12};
    r = $urandom_range(0, 9);
    if (r < 7)       hi = 32'hC000 + $urandom_range(0, 3) * 16 + $urandom_range(0, 15);
    else if (r == 7) hi = 32'hC040 + $urandom_range(0, 255);
    else if (r == 8) hi = 32'hBF00 + $urandom_range(0, 255);
    else             hi = 32'hC000 + $urandom_range(0, 63);
    set_t({hi[15:0], 16'($urandom)}, 1'($urandom), 3'($urandom_range(0, 3)), 4'($urandom),
          $urandom, waits[$urandom_range(0, 7)], ($urandom_range(0, 3) == 0));
  endtask

  // Present the t_* address phase on the bus.
  task automatic issue();
    c_addr = t_addr; c_write = t_write; c_size = t_size; c_prot = t_prot;
    c_wdata = t_wdata; c_wait = t_wait; c_err = t_err;
    for (int i = 0; i < PN; i++) PRDATA[32*i +: 32] = $urandom;
    HSEL = 1'b1; HTRANS = {1'b1, 1'($urandom)}; HADDR = t_addr; HWRITE = t_write;
    HSIZE = t_size; HPROT = t_prot; HREADYIN = 1'b1;
  endtask

  // Data phase: play APB slave, measure the response, compare with the model.
  // Entered #1 after the edge that sampled the address. chain=1 presents the
  // t_* transfer in the completion cycle.
  task automatic finish(input bit chain);
    bit           hit, tmo, exp_err, seen;
    int unsigned  slot, lowc, k, enc, setc, err1c, exp_low, exp_en;
    logic [PN-1:0] psel_or, sel1h;
    logic [31:0]  paddr_s, pwdata_s;
    logic         pwrite_s;
    logic [3:0]   pstrb_s;
    logic [2:0]   pprot_s;
    hit = m_hit(c_addr);
    slot = m_slot(c_addr);
    sel1h = hit ? (PN'(1) << slot) : '0;
    tmo = hit && (c_wait >= TO);
    exp_err = !hit || tmo || c_err;
    exp_en = !hit ? 0 : (tmo ? TO : c_wait + 1);
    exp_low = !hit ? 1 : (tmo ? 2 + TO + 1 : 3 + c_wait + (c_err ? 1 : 0));
    if (hit && c_write) m_pwdata = c_wdata;
    lowc = 0; k = 0; enc = 0; setc = 0; err1c = 0; seen = 0; psel_or = '0;
    paddr_s = '0; pwdata_s = '0; pwrite_s = 1'b0; pstrb_s = '0; pprot_s = '0;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = c_wdata;
    while (HREADYOUT !== 1'b1 && lowc < 60) begin
      lowc++;
      if (PSEL != '0) begin
        psel_or |= PSEL;
        if (!PENABLE) setc++;
        if (!seen) begin
          seen = 1; paddr_s = PADDR; pwrite_s = PWRITE; pstrb_s = PSTRB;
          pprot_s = PPROT; pwdata_s = PWDATA;
        end
      end
      if (PENABLE) enc++;
      if (HRESP) err1c++;
      // Non-selected slots get noise; the selected one follows the plan.
      PREADY = PN'($urandom) & ~sel1h;
      PSLVERR = PN'($urandom) & ~sel1h;
      if (PENABLE) begin
        k++;
        if (k > c_wait) begin
          PREADY |= sel1h;
          if (c_err) PSLVERR |= sel1h;
        end
      end
      @(posedge HCLK); #1;
    end
    chk("hready_low_cycles", lowc, exp_low);
    chk("penable_cycles", enc, exp_en);
    chk("setup_cycles", setc, hit ? 1 : 0);
    chk("psel_onehot", 32'(psel_or), 32'(sel1h));
    chk("err1_cycles", err1c, exp_err ? 1 : 0);
    chk("hresp_at_done", 32'(HRESP), 32'(exp_err));
    if (hit) begin
      chk("paddr", paddr_s, c_addr);
      chk("pwrite", 32'(pwrite_s), 32'(c_write));
      chk("pstrb", 32'(pstrb_s), 32'(m_strb(c_write, c_size, c_addr)));
      chk("pprot", 32'(pprot_s), 32'(m_pprot(c_prot)));
      chk("pwdata", pwdata_s, m_pwdata);
    end
    if (hit && !c_write && !tmo) m_hrdata = PRDATA[32*slot +: 32];
    chk("hrdata", HRDATA, m_hrdata);
    PREADY = '0; PSLVERR = '0;
    if (chain) begin
      issue();
    end else if (exp_err) begin
      @(posedge HCLK); #1;
      chk("okay_after_err", {30'd0, HREADYOUT, HRESP}, 32'b10);
    end
  endtask

  task automatic xfer();
    issue();
    @(posedge HCLK); #1;
    finish(0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned lim;
    bit chain;
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0;
    HPROT = 4'd0; HWDATA = '0; HREADYIN = 1'b1; PRDATA = '0; PREADY = '0; PSLVERR = '0;
    m_hrdata = '0; m_pwdata = '0;
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("rst_hresp", 32'(HRESP), 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_pwrite_pstrb_pprot", {24'd0, PWRITE, PSTRB, PPROT}, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    @(negedge HCLK); HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Word write to slot 0, zero wait.
    set_t(32'hC000_0004, 1, 3'd2, 4'b0011, 32'hDEAD_BEEF, 0, 0); xfer();
    // Read from slot 3 with two PREADY waits.
    set_t(32'hC030_0015, 0, 3'd2, 4'b0001, 32'h0, 2, 0);
    issue();
    PRDATA[127:96] = 32'h2211_0011;
    @(posedge HCLK); #1;
    finish(0);
    chk("hrdata_directed", HRDATA, 32'h2211_0011);
    // Unmapped: first address past the last slot.
    set_t(32'hC040_0000, 1, 3'd2, 4'b0000, 32'h1234_5678, 0, 0); xfer();
    // Byte write with slave error.
    set_t(32'hC020_0005, 1, 3'd0, 4'b0010, 32'hA5A5_A5A5, 0, 1); xfer();
    // PREADY never returns: timeout, then a normal slot-0 transfer.
    set_t(32'hC010_0100, 1, 3'd2, 4'b0001, 32'h0BAD_F00D, 1000, 0); xfer();
    set_t(32'hC000_0008, 1, 3'd1, 4'b0001, 32'h0000_BEEF, 1, 0); xfer();
    // Back-to-back: read presented in the write's completion cycle.
    set_t(32'hC000_0010, 1, 3'd2, 4'b0001, 32'h1357_9BDF, 0, 0);
    issue();
    set_t(32'hC010_0020, 0, 3'd2, 4'b0001, 32'h0, 1, 0);
    @(posedge HCLK); #1;
    finish(1);
    @(posedge HCLK); #1;
    finish(0);

    // Transfers that must be ignored: IDLE, unselected, HREADYIN low, BUSY.
    for (int i = 0; i < 4; i++) begin
      HADDR = 32'hC000_0000; HWRITE = 1'b1; HREADYIN = 1'b1; HSEL = 1'b1; HTRANS = 2'b00;
      if (i == 1) begin HSEL = 1'b0; HTRANS = 2'b10; end
      if (i == 2) begin HTRANS = 2'b10; HREADYIN = 1'b0; end
      if (i == 3) HTRANS = 2'b01;
      @(posedge HCLK); #1;
      chk("ignored_okay", {30'd0, HREADYOUT, HRESP}, 32'b10);
      chk("ignored_no_psel", 32'(PSEL), 32'd0);
    end
    HSEL = 1'b0; HTRANS = 2'b00; HREADYIN = 1'b1;
    @(posedge HCLK); #1;

    // Reset during ACCESS.
    set_t(32'hC020_0000, 0, 3'd2, 4'b0001, 32'h0, 1000, 0);
    issue();
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    lim = 0;
    while (PENABLE !== 1'b1 && lim < 10) begin
      lim++;
      @(posedge HCLK); #1;
    end
    chk("reached_access", 32'(PENABLE), 32'd1);
    #2 HRESETn = 1'b0;
    #1;
    chk("arst_psel", 32'(PSEL), 32'd0);
    chk("arst_penable", 32'(PENABLE), 32'd0);
    chk("arst_hready_hresp", {30'd0, HREADYOUT, HRESP}, 32'b10);
    m_hrdata = '0; m_pwdata = '0;
    @(negedge HCLK); HRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge HCLK); #1;
      chk("post_rst_quiet", {29'd0, HREADYOUT, HRESP, PENABLE}, 32'b100);
    end

    // Randomized traffic, some issued in the previous completion cycle.
    rand_t();
    issue();
    @(posedge HCLK); #1;
    for (int n = 0; n < 60; n++) begin
      chain = (n < 59) && ($urandom_range(0, 2) == 0);
      rand_t();
      finish(chain);
      if (!chain && n < 59) begin
        repeat ($urandom_range(0, 2)) begin @(posedge HCLK); #1; end
        issue();
        @(posedge HCLK); #1;
      end else if (chain) begin
        @(posedge HCLK); #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_to_apb_bridge_nslv.md
Name: ahb_to_apb_bridge_nslv

Overview:
Single-clock AHB-Lite slave to APB4 master bridge with P_NUM parametrised peripheral slots, the successor to the fixed 4-slot bridge. It decodes HADDR[31:16] into equal-size regions, runs one APB transfer per AHB transfer and generates PSTRB and PPROT. It maps PSLVERR, unmapped addresses and a PREADY timeout to a two-cycle AHB ERROR response. It sits between the AHB interconnect and the APB peripheral cluster; PCLK is HCLK.

Parameters:
ADDR_WIDTH, 32, address width (>=17)
DATA_WIDTH, 32, data width (fixed 32 in this generation)
P_NUM, 4, number of APB slaves, 1..16
P_BASE, 16'hC000, HADDR[31:16] value of slot 0
P_STRIDE, 16'h0010, HADDR[31:16] span per slot; power of two
P_TIMEOUT, 256, max ACCESS cycles with PREADY low before error; 0 disables the timeout

Ports:
HCLK  in  1  bridge clock (also APB clock)
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  AHB slave select
HADDR  in  ADDR_WIDTH  AHB address
HTRANS  in  2  AHB transfer type
HWRITE  in  1  write=1
HSIZE  in  3  transfer size (0,1,2 legal)
HPROT  in  4  protection
HWDATA  in  32  write data (data phase)
HREADYIN  in  1  bus ready
HREADYOUT  out  1  bridge ready
HRESP  out  1  1=ERROR
HRDATA  out  32  read data
PSEL  out  P_NUM  one-hot slave select
PENABLE  out  1  APB access phase
PADDR  out  ADDR_WIDTH  APB address
PWRITE  out  1  APB direction
PWDATA  out  32  APB write data
PSTRB  out  4  byte strobes
PPROT  out  3  APB protection
PRDATA  in  P_NUM*32  slave read data; slot i at [32i+31:32i]
PREADY  in  P_NUM  slave ready
PSLVERR  in  P_NUM  slave error

Behaviour:
- Reset (async): state IDLE. HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, PSTRB=0, PPROT=0, timeout counter=0. Asserting reset mid-transfer drops PSEL/PENABLE immediately; no completion follows.
- valid = HSEL & HTRANS[1] & HREADYIN, sampled at posedge in IDLE or ERR2. IDLE/BUSY or unselected transfers get zero-wait OKAY and the state stays IDLE.
- Decode: off = HADDR[31:16]-P_BASE. Hit iff HADDR[31:16]>=P_BASE and off < P_NUM*P_STRIDE. Slot = off/P_STRIDE, implemented as a shift.
- On valid: latch HADDR, HWRITE, HSIZE, HPROT and the slot. Hit -> LATCH; miss -> ERR1, with no APB activity.
- LATCH: HREADYOUT=0. At the next posedge, capture HWDATA into PWDATA (writes only) -> SETUP.
- SETUP: PSEL[slot]=1, PENABLE=0 for exactly one cycle -> ACCESS.
- ACCESS: PENABLE=1. At a posedge with PREADY[slot]=1:
  - read: HRDATA <= PRDATA[slot].
  - PSLVERR[slot]=0 -> IDLE with HREADYOUT=1, HRESP=0.
  - PSLVERR[slot]=1 -> ERR1.
  - PSEL/PENABLE deassert in both cases.
- Timeout: counter increments each ACCESS cycle with PREADY low. When it reaches P_TIMEOUT, go to ERR1 and drop PSEL/PENABLE. The counter clears on SETUP.
- ERR1: HREADYOUT=0, HRESP=1. ERR2: HREADYOUT=1, HRESP=1, then IDLE. A valid transfer sampled in ERR2 is accepted as in IDLE.
- Minimum latency with PREADY=1: HREADYOUT low for 3 cycles. Each PREADY wait adds 1 cycle. Error adds ERR1.
- PADDR/PWRITE/PPROT hold their latched values from SETUP until the next transfer; PWDATA holds until the next write.
- PSTRB, reads: always 0000. Writes, by HSIZE:
  - HSIZE 0: one-hot on HADDR[1:0].
  - HSIZE 1: 0011 or 1100 by HADDR[1].
  - HSIZE 2: 1111.
  - HSIZE >2: treated as 1111.
- PPROT[0]=HPROT[1], PPROT[1]=0 (secure), PPROT[2]=~HPROT[0].
- HRDATA holds the last completed read value; writes and errors do not change it, except an errored read, which still loads PRDATA.

Test Plan:
- Reset; write 0xC000_0004 = 0xDEAD_BEEF, HSIZE=2, PREADY=1 -> PSEL=0001 for 2 cycles, PADDR=C000_0004, PWDATA=DEADBEEF, PSTRB=1111, HREADYOUT low 3 cycles, HRESP=0.
- Read 0xC030_0015, PRDATA slot3=0x2211_0011, PREADY[3] low 2 ACCESS cycles -> HREADYOUT low 5 cycles, HRDATA=2211_0011, PSTRB=0000, PWRITE=0.
- Write 0xC040_0000 (unmapped, P_NUM=4) -> PSEL stays 0; HREADYOUT=0/HRESP=1 one cycle, then HREADYOUT=1/HRESP=1, then OKAY.
- Byte write 0xC020_0005 (HSIZE=0) with PSLVERR[2]=1 -> PSTRB=0010, PSEL=0100, two-cycle ERROR response.
- P_TIMEOUT=8, PREADY[1] held 0 on write 0xC010_0100 -> PENABLE high exactly 8 cycles, PSEL drops, two-cycle ERROR; the next transfer to slot0 completes OKAY.
- Back-to-back: new read address presented in the completion cycle of a write is accepted without an idle cycle. Separately, HRESETn asserted during ACCESS -> PSEL=0, PENABLE=0, HREADYOUT=1 asynchronously; no completion.
